// File: rtl/text_console_writer.sv
// Character-stream front end for the glyph map: tracks a text cursor, decodes control codes
// and drives one registered glyph-map write per printable character or clear step.
module text_console_writer #(
  parameter int unsigned       MAP_SIZE_X     = 80,
  parameter int unsigned       MAP_SIZE_Y     = 60,
  parameter int unsigned       ID_SIZE        = 7,
  parameter int unsigned       ADDR_WIDTH     = 13,
  parameter logic [ID_SIZE-1:0] BLANK_ID      = 7'h20,
  parameter bit                CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  char_valid,
  input  logic [ID_SIZE-1:0]    char_data,
  output logic                  char_ready,
  input  logic                  clear_req,
  output logic                  write_glyph,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [ID_SIZE-1:0]    glyph_id,
  output logic [6:0]            cursor_x,
  output logic [5:0]            cursor_y,
  output logic                  busy
);

  localparam logic [6:0]            XLast    = 7'(MAP_SIZE_X - 1);
  localparam logic [5:0]            YLast    = 6'(MAP_SIZE_Y - 1);
  localparam logic [ADDR_WIDTH-1:0] RowStep  = ADDR_WIDTH'(MAP_SIZE_X);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(MAP_SIZE_X * MAP_SIZE_Y - 1);
  localparam logic [ID_SIZE-1:0]    ChBs     = ID_SIZE'(8'h08);
  localparam logic [ID_SIZE-1:0]    ChLf     = ID_SIZE'(8'h0A);
  localparam logic [ID_SIZE-1:0]    ChFf     = ID_SIZE'(8'h0C);
  localparam logic [ID_SIZE-1:0]    ChCr     = ID_SIZE'(8'h0D);
  localparam logic [ID_SIZE-1:0]    ChSpace  = ID_SIZE'(8'h20);
  localparam logic [ID_SIZE-1:0]    ChTilde  = ID_SIZE'(8'h7E);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e                  state_q, state_d;
  logic                    init_q, init_d;
  logic [6:0]              x_q, x_d;
  logic [5:0]              y_q, y_d;
  logic [ADDR_WIDTH-1:0]   row_base_q, row_base_d;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ID_SIZE-1:0]      glyph_q, glyph_d;

  logic                    accept;
  logic                    do_clear;
  logic                    printable;
  logic [5:0]              y_next;
  logic [ADDR_WIDTH-1:0]   row_next;

  // The power-on clear owns the first cycle after reset, so no char may slip in ahead of it.
  assign char_ready = (state_q == StIdle) & ~clear_req & ~init_q;
  assign accept     = char_valid & char_ready;
  assign do_clear   = (state_q == StIdle) & (clear_req | init_q | (accept & (char_data == ChFf)));
  assign printable  = (char_data >= ChSpace) & (char_data <= ChTilde);

  // Row advance with wrap to the top; no scrolling.
  assign y_next   = (y_q == YLast) ? 6'd0 : y_q + 6'd1;
  assign row_next = (y_q == YLast) ? '0 : row_base_q + RowStep;

  always_comb begin
    state_d    = state_q;
    init_d     = 1'b0;
    x_d        = x_q;
    y_d        = y_q;
    row_base_d = row_base_q;
    write_d    = 1'b0;
    addr_d     = addr_q;
    glyph_d    = glyph_q;

    unique case (state_q)
      StIdle: begin
        if (do_clear) begin
          state_d = StClear;
          write_d = 1'b1;
          addr_d  = '0;
          glyph_d = BLANK_ID;
        end else if (accept) begin
          if (printable) begin
            write_d = 1'b1;
            addr_d  = row_base_q + ADDR_WIDTH'(x_q);
            glyph_d = char_data;
            if (x_q == XLast) begin
              x_d        = 7'd0;
              y_d        = y_next;
              row_base_d = row_next;
            end else begin
              x_d = x_q + 7'd1;
            end
          end else if (char_data == ChLf) begin
            x_d        = 7'd0;
            y_d        = y_next;
            row_base_d = row_next;
          end else if (char_data == ChCr) begin
            x_d = 7'd0;
          end else if (char_data == ChBs) begin
            if (x_q != 7'd0) begin
              x_d     = x_q - 7'd1;
              write_d = 1'b1;
              addr_d  = row_base_q + ADDR_WIDTH'(x_q - 7'd1);
              glyph_d = BLANK_ID;
            end else if (y_q != 6'd0) begin
              // Last column of the previous row sits one below this row's base.
              x_d        = XLast;
              y_d        = y_q - 6'd1;
              row_base_d = row_base_q - RowStep;
              write_d    = 1'b1;
              addr_d     = row_base_q - ADDR_WIDTH'(1);
              glyph_d    = BLANK_ID;
            end
          end
        end
      end
      StClear: begin
        // addr_q doubles as the clear sweep counter.
        if (addr_q == LastAddr) begin
          state_d    = StIdle;
          x_d        = 7'd0;
          y_d        = 6'd0;
          row_base_d = '0;
        end else begin
          write_d = 1'b1;
          addr_d  = addr_q + ADDR_WIDTH'(1);
          glyph_d = BLANK_ID;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      init_q     <= CLEAR_ON_RESET;
      x_q        <= 7'd0;
      y_q        <= 6'd0;
      row_base_q <= '0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      glyph_q    <= '0;
    end else begin
      state_q    <= state_d;
      init_q     <= init_d;
      x_q        <= x_d;
      y_q        <= y_d;
      row_base_q <= row_base_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      glyph_q    <= glyph_d;
    end
  end

  assign write_glyph = write_q;
  assign addr        = addr_q;
  assign glyph_id    = glyph_q;
  assign cursor_x    = x_q;
  assign cursor_y    = y_q;
  assign busy        = (state_q == StClear);

endmodule

// File: tb/tb_text_console_writer.sv
// Scoreboard bench for text_console_writer: stimulus queues expected glyph writes, a monitor
// pops and compares every write the DUT presents.
module tb_text_console_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        char_valid = 1'b0;
  logic [6:0]  char_data = 7'h00;
  logic        char_ready;
  logic        clear_req = 1'b0;
  logic        write_glyph;
  logic [12:0] addr;
  logic [6:0]  glyph_id;
  logic [6:0]  cursor_x;
  logic [5:0]  cursor_y;
  logic        busy;

  text_console_writer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .char_valid  (char_valid),
    .char_data   (char_data),
    .char_ready  (char_ready),
    .clear_req   (clear_req),
    .write_glyph (write_glyph),
    .addr        (addr),
    .glyph_id    (glyph_id),
    .cursor_x    (cursor_x),
    .cursor_y    (cursor_y),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned a;
    int unsigned g;
    bit          clr;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  int unsigned last_wr = 0;
  int unsigned wr_gap  = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic push(input int unsigned a, input int unsigned g, input bit clr);
    exp_t e;
    e.a = a;
    e.g = g;
    e.clr = clr;
    sb.push_back(e);
  endtask

  task automatic push_clear();
    for (int i = 0; i < 4800; i++) push(i, 32'h20, 1'b1);
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [6:0] c);
    int n;
    n = 0;
    char_valid = 1'b1;
    char_data  = c;
    do begin
      @(negedge clk);
      n++;
    end while (!char_ready && n < 12000);
    if (!char_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    char_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sb.size() != 0 || busy) && n < 12000);
    if (n >= 12000) chk(name, 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cursor(input string name, input int unsigned x, input int unsigned y);
    chk({name, "_x"}, cursor_x, x);
    chk({name, "_y"}, cursor_y, y);
  endtask

  initial begin
    // Monitor runs as a child of this block so all counters stay in one process tree.
    fork
      forever begin
        @(negedge clk);
        cyc++;
        if (rst_n && write_glyph) begin
          wr_gap  = cyc - last_wr;
          last_wr = cyc;
          if (sb.size() == 0) begin
            chk("unexpected_write_addr", addr, 32'hFFFF);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("wr_addr", addr, e.a);
            chk("wr_glyph", glyph_id, e.g);
            if (e.clr) begin
              chk("clr_busy", busy, 1);
              chk("clr_ready", char_ready, 0);
            end
          end
        end
      end
    join_none

    #1 rst_n = 1'b0;
    #2;
    chk("rst_write", write_glyph, 0);
    chk("rst_addr", addr, 0);
    chk("rst_glyph", glyph_id, 0);
    chk("rst_busy", busy, 0);
    chk_cursor("rst_cursor", 0, 0);

    // Power-on clear.
    push_clear();
    #10 rst_n = 1'b1;
    wait_drain("por_clear_timeout");
    chk_cursor("por_cursor", 0, 0);
    chk("por_ready", char_ready, 1);
    chk("por_busy", busy, 0);

    // "AB" back-to-back.
    push(0, 32'h41, 1'b0);
    push(1, 32'h42, 1'b0);
    send(7'h41);
    send(7'h42);
    wait_drain("ab_timeout");
    chk("ab_gap", wr_gap, 1);
    chk_cursor("ab_cursor", 2, 0);

    // CR, 3xLF, 5 chars -> (5,3); LF -> (0,4); BS -> (79,3) with blank at 319.
    send(7'h0D);
    chk_cursor("cr_cursor", 0, 0);
    for (int i = 0; i < 3; i++) send(7'h0A);
    for (int i = 0; i < 5; i++) begin
      push(240 + i, 32'h78, 1'b0);
      send(7'h78);
    end
    wait_drain("row3_timeout");
    chk_cursor("pre_lf_cursor", 5, 3);
    send(7'h0A);
    chk_cursor("lf_cursor", 0, 4);
    push(319, 32'h20, 1'b0);
    send(7'h08);
    wait_drain("bs_timeout");
    chk_cursor("bs_cursor", 79, 3);

    // Walk to (79,59) and write 'Z' at the last cell; cursor wraps to (0,0).
    send(7'h0D);
    for (int i = 0; i < 56; i++) send(7'h0A);
    chk_cursor("row59_cursor", 0, 59);
    for (int i = 0; i < 79; i++) begin
      push(4720 + i, 32'h61, 1'b0);
      send(7'h61);
    end
    wait_drain("row59_fill_timeout");
    chk_cursor("pre_z_cursor", 79, 59);
    push(4799, 32'h5A, 1'b0);
    send(7'h5A);
    wait_drain("z_timeout");
    chk_cursor("z_cursor", 0, 0);

    // BS at home and a non-printing code: no write, cursor unchanged.
    send(7'h08);
    send(7'h01);
    wait_drain("noop_timeout");
    chk_cursor("noop_cursor", 0, 0);
    chk("noop_gap_idle", write_glyph, 0);

    // clear_req wins over a simultaneous char; the char stays pending and lands at addr 0.
    push_clear();
    push(0, 32'h51, 1'b0);
    clear_req  = 1'b1;
    char_valid = 1'b1;
    char_data  = 7'h51;
    @(negedge clk);
    chk("collide_ready", char_ready, 0);
    @(posedge clk);
    #1 clear_req = 1'b0;
    send(7'h51);
    wait_drain("collide_timeout");
    chk_cursor("collide_cursor", 1, 0);

    // FF clears; a clear_req pulse mid-clear is ignored.
    push_clear();
    send(7'h0C);
    repeat (50) @(posedge clk);
    #1 clear_req = 1'b1;
    @(posedge clk);
    #1 clear_req = 1'b0;
    wait_drain("ff_timeout");
    chk_cursor("ff_cursor", 0, 0);

    // Reset around clear write 100 aborts; release restarts a full clear from 0.
    push_clear();
    clear_req = 1'b1;
    @(posedge clk);
    #1 clear_req = 1'b0;
    begin
      int n;
      n = 0;
      while (sb.size() > 4699 && n < 12000) begin
        @(posedge clk);
        n++;
      end
      if (n >= 12000) chk("abort_wait_timeout", 0, 1);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("abort_write", write_glyph, 0);
    chk("abort_addr", addr, 0);
    chk("abort_glyph", glyph_id, 0);
    chk("abort_busy", busy, 0);
    chk_cursor("abort_cursor", 0, 0);
    sb.delete();
    push_clear();
    @(negedge clk);
    #1 rst_n = 1'b1;
    wait_drain("restart_timeout");
    chk_cursor("restart_cursor", 0, 0);
    chk("restart_ready", char_ready, 1);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
